// File: rtl/perf_report_uart_if.sv
// Report bus between the phase controller and the UART report block.
interface perf_report_uart_if;
  logic [31:0] counter1;
  logic [31:0] counter2;
  logic        stop1;
  logic        stop2;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output counter1, counter2, stop1, stop2, input tx, busy, done);
  modport slave  (input counter1, counter2, stop1, stop2, output tx, busy, done);
endinterface

// File: rtl/perf_report_uart.sv
// Sends a 9-byte report frame (header + two 32-bit phase counts, MSB byte first)
// over an 8N1 UART once both phases have completed.
module perf_report_uart #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  perf_report_uart_if.slave bus
);
  localparam int unsigned          BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]           LAST_BYTE = 4'd8;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_BIT = 2'd1;
  localparam logic [1:0] DATA_BITS = 2'd2;
  localparam logic [1:0] STOP_BIT  = 2'd3;

  logic [1:0]        state, state_d;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [3:0]        byte_idx, byte_idx_d;
  logic [31:0]       c1_q, c1_d;
  logic [31:0]       c2_q, c2_d;
  logic              stop2_q;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        cur_byte;
  logic [2:0]        bit_next;
  logic              baud_end;
  logic              trigger;

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign bit_next = bit_idx + 3'd1;
  assign trigger  = bus.stop2 & ~stop2_q & bus.stop1 & (state == IDLE);

  // Byte currently on the wire, selected from the frozen shadow copies.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = c1_q[31:24];
      4'd2:    cur_byte = c1_q[23:16];
      4'd3:    cur_byte = c1_q[15:8];
      4'd4:    cur_byte = c1_q[7:0];
      4'd5:    cur_byte = c2_q[31:24];
      4'd6:    cur_byte = c2_q[23:16];
      4'd7:    cur_byte = c2_q[15:8];
      default: cur_byte = c2_q[7:0];
    endcase
  end

  // Next-state and next-output logic; tx_d is the level for the next cycle.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    c1_d       = c1_q;
    c2_d       = c2_q;
    tx_d       = 1'b1;
    done_d     = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_d    = START_BIT;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          c1_d       = bus.counter1;
          c2_d       = bus.counter2;
          tx_d       = 1'b0;
        end
      end
      START_BIT: begin
        tx_d = 1'b0;
        if (baud_end) begin
          state_d    = DATA_BITS;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          tx_d       = cur_byte[0];
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      DATA_BITS: begin
        tx_d = cur_byte[bit_idx];
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_next;
            tx_d      = cur_byte[bit_next];
          end
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_cnt_d = '0;
          if (byte_idx == LAST_BYTE) begin
            state_d    = IDLE;
            byte_idx_d = '0;
            done_d     = 1'b1;
          end else begin
            state_d    = START_BIT;
            byte_idx_d = byte_idx + 4'd1;
            tx_d       = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // stop2_q resets high so a level held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      stop2_q  <= 1'b1;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      stop2_q  <= bus.stop2;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_perf_report_uart.sv
// Bench for perf_report_uart: two instances (4 and 2 clocks per bit) checked
// against a bit-list frame model and a mid-bit UART receiver.
module tb_perf_report_uart;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  perf_report_uart_if if4 ();
  perf_report_uart_if if2 ();

  perf_report_uart #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  perf_report_uart #(.CLKS_PER_BIT(2), .HEADER(8'hA5)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c1;
    logic [31:0] c2;
    logic        stop1;
    logic        exp_frame;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cpb(input int s);
    return (s == 0) ? 4 : 2;
  endfunction

  function automatic logic get_tx(input int s);
    return (s == 0) ? if4.tx : if2.tx;
  endfunction

  function automatic logic get_busy(input int s);
    return (s == 0) ? if4.busy : if2.busy;
  endfunction

  function automatic logic get_done(input int s);
    return (s == 0) ? if4.done : if2.done;
  endfunction

  task automatic set_stop1(input int s, input logic v);
    if (s == 0) if4.stop1 = v; else if2.stop1 = v;
  endtask

  task automatic set_stop2(input int s, input logic v);
    if (s == 0) if4.stop2 = v; else if2.stop2 = v;
  endtask

  task automatic set_cnt(input int s, input logic [31:0] a, input logic [31:0] b);
    if (s == 0) begin if4.counter1 = a; if4.counter2 = b; end
    else        begin if2.counter1 = a; if2.counter2 = b; end
  endtask

  // Watch n cycles in which the line must stay idle and no pulse may appear.
  task automatic idle_watch(input int s, input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (get_tx(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_done(s) !== 1'b0) bad++;
      tick();
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Raise stop2 with stop1 high and check the complete frame that must follow.
  task automatic run_frame(input int s, input logic [31:0] c1, input logic [31:0] c2,
                           input bit scramble, input bit midpulse, input string tag);
    logic [7:0] expb [9];
    logic       bitv [90];
    logic       rx   [90];
    int         p, n, first_tx, busy_cnt, done_cnt;
    p = cpb(s);
    n = 90 * p;
    first_tx = -1;
    busy_cnt = 0;
    done_cnt = 0;
    expb[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      expb[1 + i] = 8'(c1 >> (24 - 8 * i));
      expb[5 + i] = 8'(c2 >> (24 - 8 * i));
    end
    for (int b = 0; b < 9; b++) begin
      bitv[b * 10] = 1'b0;
      for (int k = 0; k < 8; k++) bitv[b * 10 + 1 + k] = expb[b][k];
      bitv[b * 10 + 9] = 1'b1;
    end
    for (int i = 0; i < 90; i++) rx[i] = 1'bx;

    set_cnt(s, c1, c2);
    set_stop1(s, 1'b1);
    set_stop2(s, 1'b1);
    tick();
    for (int cyc = 0; cyc < n; cyc++) begin
      if (get_tx(s) !== bitv[cyc / p] && first_tx < 0) first_tx = cyc;
      if (get_busy(s) === 1'b1) busy_cnt++;
      if (get_done(s) !== 1'b0) done_cnt++;
      if (cyc % p == p / 2) rx[cyc / p] = get_tx(s);
      if (scramble && cyc == 0) set_cnt(s, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      if (midpulse && cyc == 100) set_stop2(s, 1'b0);
      if (midpulse && cyc == 104) set_stop2(s, 1'b1);
      tick();
    end
    check($sformatf("%s_tx_first_bad_cycle", tag), 32'(first_tx), 32'hFFFF_FFFF);
    check($sformatf("%s_busy_cycles", tag), 32'(busy_cnt), 32'(n));
    check($sformatf("%s_done_in_frame", tag), 32'(done_cnt), 32'd0);
    for (int b = 0; b < 9; b++) begin
      logic [7:0] got;
      for (int k = 0; k < 8; k++) got[k] = rx[b * 10 + 1 + k];
      check($sformatf("%s_byte%0d", tag, b), 32'(got), 32'(expb[b]));
      check($sformatf("%s_framing%0d", tag, b), 32'({rx[b * 10], rx[b * 10 + 9]}), 32'b01);
    end
    check($sformatf("%s_busy_end", tag), 32'(get_busy(s)), 32'd0);
    check($sformatf("%s_done_pulse", tag), 32'(get_done(s)), 32'd1);
    tick();
    check($sformatf("%s_done_clear", tag), 32'(get_done(s)), 32'd0);
    check($sformatf("%s_tx_idle", tag), 32'(get_tx(s)), 32'd1);
  endtask

  initial begin
    vec_t vt [5];
    vt[0] = '{c1: 32'h1234_5678, c2: 32'h0000_ABCD, stop1: 1'b1, exp_frame: 1'b1};
    vt[1] = '{c1: 32'h0000_0000, c2: 32'hFFFF_FFFF, stop1: 1'b1, exp_frame: 1'b1};
    vt[2] = '{c1: 32'hDEAD_BEEF, c2: 32'h0102_0304, stop1: 1'b0, exp_frame: 1'b0};
    vt[3] = '{c1: 32'h8000_0001, c2: 32'h5555_AAAA, stop1: 1'b1, exp_frame: 1'b1};
    vt[4] = '{c1: 32'hCAFE_F00D, c2: 32'h0000_0000, stop1: 1'b0, exp_frame: 1'b0};

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      set_cnt(s, 32'd0, 32'd0);
      set_stop1(s, 1'b1);
      set_stop2(s, 1'b1);
    end
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_tx_%0d", s), 32'(get_tx(s)), 32'd1);
      check($sformatf("reset_busy_%0d", s), 32'(get_busy(s)), 32'd0);
      check($sformatf("reset_done_%0d", s), 32'(get_done(s)), 32'd0);
    end
    reset = 1'b0;
    idle_watch(0, 30, "held_stop2_release_4");
    idle_watch(1, 30, "held_stop2_release_2");
    set_stop2(0, 1'b0);
    set_stop2(1, 1'b0);
    tick();

    // Table of qualifying and non-qualifying stop2 edges.
    for (int i = 0; i < 5; i++) begin
      if (vt[i].exp_frame) begin
        run_frame(0, vt[i].c1, vt[i].c2, 1'b0, 1'b0, $sformatf("vec%0d", i));
      end else begin
        set_cnt(0, vt[i].c1, vt[i].c2);
        set_stop1(0, vt[i].stop1);
        set_stop2(0, 1'b1);
        tick();
        idle_watch(0, 400, $sformatf("vec%0d_no_frame", i));
      end
      set_stop2(0, 1'b0);
      set_stop1(0, 1'b1);
      tick();
    end

    run_frame(0, 32'h1234_5678, 32'h0000_ABCD, 1'b1, 1'b0, "capture");
    set_stop2(0, 1'b0);
    tick();

    run_frame(0, 32'h1234_5678, 32'h0000_ABCD, 1'b0, 1'b1, "retrig_a");
    idle_watch(0, 60, "retrig_held_high");
    set_stop2(0, 1'b0);
    tick();
    run_frame(0, 32'h1234_5678, 32'h0000_ABCD, 1'b0, 1'b0, "retrig_b");
    set_stop2(0, 1'b0);
    tick();

    run_frame(1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "cpb2");
    set_stop2(1, 1'b0);
    tick();

    // Abort during byte 3 (cycles 120..159 of the frame).
    set_cnt(0, 32'h1234_5678, 32'h0000_ABCD);
    set_stop1(0, 1'b1);
    set_stop2(0, 1'b1);
    tick();
    repeat (135) tick();
    check("abort_busy_before", 32'(get_busy(0)), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_tx", 32'(get_tx(0)), 32'd1);
    check("abort_busy", 32'(get_busy(0)), 32'd0);
    check("abort_done", 32'(get_done(0)), 32'd0);
    idle_watch(0, 100, "abort_no_frame");
    set_stop2(0, 1'b0);
    tick();

    // Random counters and qualification on either instance.
    for (int r = 0; r < 8; r++) begin
      int          s;
      logic [31:0] a, b;
      logic        q;
      s = int'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      q = ($urandom_range(0, 3) != 0);
      if (q) begin
        run_frame(s, a, b, 1'b0, 1'b0, $sformatf("rand%0d", r));
      end else begin
        set_cnt(s, a, b);
        set_stop1(s, 1'b0);
        set_stop2(s, 1'b1);
        tick();
        idle_watch(s, 200, $sformatf("rand%0d_no_frame", r));
      end
      set_stop2(s, 1'b0);
      set_stop1(s, 1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
